uart_tx_param: RTL and testbench

Parametrised UART transmit engine with an integrated transmit FIFO. It serialises words of 5 to MAX_DATA_W bits with optional parity (odd, even or stick), 1 or 2 stop bits, and a break condition, using an OVERSAMPLE-tick bit period. It sits between the memory-mapped UART register interface (FIFO writes, line control, status) and the TXD pad. Line configuration is latched per frame, so software may change it while a frame is in flight.

---
 rtl/uart_tx_param.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx_param.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: UART transmit engine with an integrated transmit FIFO and per-frame latched line settings.
// Define UART_TX_CTS_EN to add the cts_n flow-control input.
module uart_tx_param #(
    parameter int OVERSAMPLE = 16,
    parameter int MAX_DATA_W = 9,
    parameter int FIFO_DEPTH = 8,
    parameter int LW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  baud_tick,
    input  logic                  cfg_en,
    input  logic [3:0]            cfg_word_len,
    input  logic                  cfg_parity_en,
    input  logic                  cfg_even,
    input  logic                  cfg_stick,
    input  logic                  cfg_stop2,
    input  logic                  cfg_break,
    input  logic                  wr_valid,
    input  logic [MAX_DATA_W-1:0] wr_data,
`ifdef UART_TX_CTS_EN
    input  logic                  cts_n,
`endif
    output logic                  wr_ready,
    output logic [LW-1:0]         fifo_level,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  tx_busy,
    output logic                  txd
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {
        S_DISABLE, S_IDLE, S_BREAK, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    logic [MAX_DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wptr, r_rptr;
    logic [LW-1:0]         r_level;
    state_t                r_state, w_state;
    logic                  r_txd, w_txd;
    logic [CW-1:0]         r_tick, w_tick;
    logic [3:0]            r_bit, w_bit;
    logic                  r_par, w_par;
    logic [MAX_DATA_W-1:0] r_shift, w_shift;
    logic [3:0]            r_wl, w_wl;
    logic                  r_pen, r_even, r_stick, r_stop2;
    logic                  w_push, w_pop, w_bit_end, w_cts_ok;

`ifdef UART_TX_CTS_EN
    assign w_cts_ok = ~cts_n;
`else
    assign w_cts_ok = 1'b1;
`endif

    assign fifo_level = r_level;
    assign fifo_empty = (r_level == '0);
    assign fifo_full  = (r_level == LW'(FIFO_DEPTH));
    assign wr_ready   = ~fifo_full;
    assign w_push     = wr_valid && !fifo_full;
    assign tx_busy    = r_state inside {S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2};
    assign txd        = r_txd;
    assign w_bit_end  = baud_tick && (r_tick == CW'(OVERSAMPLE - 1));
    assign w_wl       = (cfg_word_len < 4'd5) ? 4'd5 :
                        (cfg_word_len > 4'(MAX_DATA_W)) ? 4'(MAX_DATA_W) : cfg_word_len;

    always_ff @(posedge CLK) begin
        if (w_push)
            r_mem[r_wptr] <= wr_data;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
            r_txd   <= 1'b1;
            r_tick  <= '0;
            r_bit   <= '0;
            r_par   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_txd   <= w_txd;
            r_tick  <= w_tick;
            r_bit   <= w_bit;
            r_par   <= w_par;
        end
    end

    // Frame shadow: the popped word and line settings stay fixed for the whole frame
    always_ff @(posedge CLK) begin
        r_shift <= w_pop ? r_mem[r_rptr] : w_shift;
        if (w_pop) begin
            r_wl    <= w_wl;
            r_pen   <= cfg_parity_en;
            r_even  <= cfg_even;
            r_stick <= cfg_stick;
            r_stop2 <= cfg_stop2;
        end
    end

    always_comb begin
        w_state = r_state;
        w_txd   = r_txd;
        w_tick  = r_tick;
        w_bit   = r_bit;
        w_par   = r_par;
        w_shift = r_shift;
        w_pop   = 1'b0;
        if (baud_tick && tx_busy)
            w_tick = w_bit_end ? '0 : r_tick + 1'b1;
        case (r_state)
            S_DISABLE: begin
                w_txd = 1'b1;
                if (cfg_en)
                    w_state = S_IDLE;
            end
            S_IDLE: begin
                if (!cfg_en) begin
                    w_state = S_DISABLE;
                end else if (cfg_break) begin
                    w_state = S_BREAK;
                    w_txd   = 1'b0;
                end else if (!fifo_empty && baud_tick && w_cts_ok) begin
                    w_state = S_START;
                    w_txd   = 1'b0;
                    w_pop   = 1'b1;
                    w_tick  = '0;
                    w_bit   = '0;
                    w_par   = 1'b0;
                end
            end
            S_BREAK: begin
                w_txd = 1'b0;
                if (!cfg_break) begin
                    w_state = S_IDLE;
                    w_txd   = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state = S_DATA;
                    w_txd   = r_shift[0];
                    w_par   = r_par ^ r_shift[0];
                    w_shift = r_shift >> 1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit == r_wl - 4'd1) begin
                        w_state = r_pen ? S_PARITY : S_STOP1;
                        w_txd   = r_pen ? (r_stick ? ~r_even : r_par ^ ~r_even) : 1'b1;
                    end else begin
                        w_bit   = r_bit + 4'd1;
                        w_txd   = r_shift[0];
                        w_par   = r_par ^ r_shift[0];
                        w_shift = r_shift >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state = S_STOP1;
                    w_txd   = 1'b1;
                end
            end
            S_STOP1: begin
                w_txd = 1'b1;
                if (w_bit_end)
                    w_state = r_stop2 ? S_STOP2 : S_IDLE;
            end
            S_STOP2: begin
                w_txd = 1'b1;
                if (w_bit_end)
                    w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
                w_txd   = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed, table-driven checks of frame formats, FIFO limits, break and mid-frame reset.
module tb_uart_tx_param;
    localparam int OS = 16;
    localparam int TP = 3;
    localparam int LIMIT = OS * TP * 3;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       baud_tick = 1'b0;
    logic       cfg_en = 1'b1;
    logic [3:0] cfg_word_len = 4'd8;
    logic       cfg_parity_en = 1'b0;
    logic       cfg_even = 1'b0;
    logic       cfg_stick = 1'b0;
    logic       cfg_stop2 = 1'b0;
    logic       cfg_break = 1'b0;
    logic       wr_valid = 1'b0;
    logic [8:0] wr_data = '0;
    logic       wr_ready;
    logic [3:0] fifo_level;
    logic       fifo_empty, fifo_full, tx_busy, txd;

    int  checks = 0;
    int  errors = 0;
    int  ph = 0;
    int  tk = 0;
    bit  tick_en = 1'b0;
    bit  last_tick = 1'b0;

    uart_tx_param dut (
        .CLK(CLK), .RSTn(RSTn), .baud_tick(baud_tick), .cfg_en(cfg_en),
        .cfg_word_len(cfg_word_len), .cfg_parity_en(cfg_parity_en), .cfg_even(cfg_even),
        .cfg_stick(cfg_stick), .cfg_stop2(cfg_stop2), .cfg_break(cfg_break),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .fifo_level(fifo_level),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .tx_busy(tx_busy), .txd(txd)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  wl;
        logic        pen, even, stick, stop2;
        logic [8:0]  data;
        int          nb;
        logic [15:0] exp;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        last_tick = baud_tick;
        @(posedge CLK);
        #1;
        ph = (ph + 1) % TP;
        baud_tick = tick_en && (ph == 0);
    endtask

    task automatic adv_to(input int target);
        int n;
        n = 0;
        while (tk < target && n < target * TP + 20) begin
            cyc();
            if (last_tick)
                tk++;
            n++;
        end
    endtask

    task automatic push(input logic [8:0] d);
        wr_valid = 1'b1;
        wr_data = d;
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic wait_start(input string nm);
        int n;
        n = 0;
        while (txd !== 1'b0 && n < LIMIT) begin
            cyc();
            n++;
        end
        chk({nm, "_start"}, txd, 0);
        tk = 0;
    endtask

    // mode 1 disturbs line settings and enable mid-frame, mode 2 raises break mid-frame
    task automatic recv(input int nb, input logic [15:0] exp, input int mode, input string nm);
        logic [15:0] got;
        wait_start(nm);
        if (mode == 1) begin
            cfg_word_len = 4'd5;
            cfg_parity_en = ~cfg_parity_en;
            cfg_stop2 = ~cfg_stop2;
            cfg_even = ~cfg_even;
            cfg_en = 1'b0;
        end
        if (mode == 2)
            cfg_break = 1'b1;
        got = '0;
        for (int b = 0; b < nb; b++) begin
            adv_to(OS * b + OS / 2);
            got[b] = txd;
        end
        adv_to(OS * nb - 1);
        chk({nm, "_busy_last"}, tx_busy, 1);
        adv_to(OS * nb);
        chk({nm, "_busy_end"}, tx_busy, 0);
        chk({nm, "_bits"}, got, exp);
    endtask

    initial begin
        bit bad;
        vt[0] = '{4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 9'h0A5, 10, 16'h034A};
        vt[1] = '{4'd7,  1'b1, 1'b1, 1'b0, 1'b1, 9'h003, 11, 16'h0606};
        vt[2] = '{4'd7,  1'b1, 1'b0, 1'b0, 1'b1, 9'h003, 11, 16'h0706};
        vt[3] = '{4'd7,  1'b1, 1'b1, 1'b1, 1'b0, 9'h003, 10, 16'h0206};
        vt[4] = '{4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 9'h1F3, 7,  16'h0066};
        vt[5] = '{4'd9,  1'b1, 1'b1, 1'b0, 1'b0, 9'h1A5, 12, 16'h0F4A};
        vt[6] = '{4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 9'h155, 11, 16'h06AA};
        vt[7] = '{4'd2,  1'b1, 1'b0, 1'b1, 1'b0, 9'h00A, 8,  16'h00D4};
        vt[8] = '{4'd8,  1'b1, 1'b0, 1'b0, 1'b0, 9'h0FF, 11, 16'h07FE};

        repeat (3) cyc();
        chk("rst_txd", txd, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_ready", wr_ready, 1);
        RSTn = 1'b1;
        tick_en = 1'b1;
        cyc();

        for (int i = 0; i < 9; i++) begin
            cfg_en = 1'b1;
            cfg_word_len = vt[i].wl;
            cfg_parity_en = vt[i].pen;
            cfg_even = vt[i].even;
            cfg_stick = vt[i].stick;
            cfg_stop2 = vt[i].stop2;
            push(vt[i].data);
            recv(vt[i].nb, vt[i].exp, 1, $sformatf("vec%0d", i));
        end
        cfg_en = 1'b1;
        cfg_word_len = 4'd8;
        cfg_parity_en = 1'b0;
        cfg_stop2 = 1'b0;

        tick_en = 1'b0;
        repeat (TP + 2) cyc();
        for (int i = 0; i < 9; i++) begin
            push(9'(16 + i));
            chk($sformatf("fill_level%0d", i), fifo_level, (i < 8) ? i + 1 : 8);
        end
        chk("full_flag", fifo_full, 1);
        chk("full_ready", wr_ready, 0);
        chk("full_empty", fifo_empty, 0);
        tick_en = 1'b1;
        for (int i = 0; i < 8; i++)
            recv(10, 16'h200 | 16'((16 + i) << 1), 0, $sformatf("drain%0d", i));
        repeat (OS * TP) cyc();
        chk("drain_empty", fifo_empty, 1);
        chk("drain_level", fifo_level, 0);
        chk("drain_idle_txd", txd, 1);

        push(9'h055);
        recv(10, 16'h02AA, 2, "brk_frame");
        repeat (3) cyc();
        chk("brk_low", txd, 0);
        bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (txd !== 1'b0)
                bad = 1'b1;
        end
        chk("brk_hold", bad, 0);
        cfg_break = 1'b0;
        repeat (2) cyc();
        chk("brk_release", txd, 1);
        push(9'h03C);
        recv(10, 16'h0278, 0, "post_brk");

        push(9'h000);
        push(9'h0FF);
        wait_start("rst_mid");
        adv_to(OS * 3 + 4);
        chk("rst_mid_busy_before", tx_busy, 1);
        RSTn = 1'b0;
        cyc();
        chk("rst_mid_txd", txd, 1);
        chk("rst_mid_level", fifo_level, 0);
        chk("rst_mid_busy", tx_busy, 0);
        RSTn = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < OS * TP * 12; i++) begin
            cyc();
            if (txd !== 1'b1 || tx_busy !== 1'b0)
                bad = 1'b1;
        end
        chk("rst_mid_silent", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
